// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
//   Shared definitions for the multichannel sample reducer.
//   - MODE_* : reduction mode encodings (2'b11 behaves as AVERAGE)
//   - state_e : framing FSM states
//   - extract_sample() : sign-extends the MSB-justified sample field of a beat
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam logic [1:0] MODE_AVERAGE = 2'b00;
  localparam logic [1:0] MODE_SELECT  = 2'b01;
  localparam logic [1:0] MODE_PEAK    = 2'b10;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_RESYNC  = 1'b1
  } state_e;

  // The sample sits in the top sw bits of a dw-bit beat. Shifting it to the
  // top of a 64-bit word and arithmetically shifting back yields the
  // sign-extended value; callers size-cast the result to their sample width.
  function automatic logic signed [63:0] extract_sample(
    input logic [63:0] tdata,
    input int unsigned dw,
    input int unsigned sw
  );
    logic signed [63:0] t;
    t = signed'(tdata << (64 - dw));
    return t >>> (64 - sw);
  endfunction

endpackage

// File: rtl/sample_window_reducer.sv
// -----------------------------------------------------------------------------
// sample_window_reducer
//   Collapses a window of max(decim,1) completed frames into one result.
//   Controls (mode/sel/decim) are captured on the first frame of a window and
//   held until the window closes.
// Ports
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_frame_vld      : one completed, well-formed frame this cycle
//   i_avg            : floor average of the frame's channels
//   i_sel_val        : frame's sample on channel o_sel_eff
//   i_mode/i_sel/i_decim : live control inputs
//   o_sel_eff        : channel index in effect (sel >= NUM_CHANNELS -> 0)
//   o_load           : result valid (last frame of window)
//   o_result         : reduced mono sample
// -----------------------------------------------------------------------------
module sample_window_reducer
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int DECIM_WIDTH  = 8,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_frame_vld,
  input  logic signed [SAMPLE_WIDTH-1:0] i_avg,
  input  logic signed [SAMPLE_WIDTH-1:0] i_sel_val,
  input  logic [1:0]                     i_mode,
  input  logic [2:0]                     i_sel,
  input  logic [DECIM_WIDTH-1:0]         i_decim,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] o_sel_eff,
  output logic                           o_load,
  output logic signed [SAMPLE_WIDTH-1:0] o_result
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [DECIM_WIDTH-1:0]         r_win_cnt;
  logic [1:0]                     r_mode_h;
  logic [2:0]                     r_sel_h;
  logic [DECIM_WIDTH-1:0]         r_decim_h;
  logic signed [SAMPLE_WIDTH-1:0] r_peak;

  logic                           w_first;
  logic [1:0]                     w_mode;
  logic [2:0]                     w_sel_src;
  logic [DECIM_WIDTH-1:0]         w_decim;
  logic [DECIM_WIDTH-1:0]         w_win_len;
  logic                           w_win_last;
  logic signed [SAMPLE_WIDTH-1:0] w_fv;
  logic signed [SAMPLE_WIDTH-1:0] w_peak_nxt;

  // Magnitude one bit wider so that |most-negative| ranks above every other value.
  function automatic logic [SAMPLE_WIDTH:0] mag(input logic signed [SAMPLE_WIDTH-1:0] x);
    logic signed [SAMPLE_WIDTH:0] xe;
    xe = (SAMPLE_WIDTH+1)'(x);
    return (xe < 0) ? unsigned'(-xe) : unsigned'(xe);
  endfunction

  assign w_first    = (r_win_cnt == '0);
  assign w_mode     = w_first ? i_mode  : r_mode_h;
  assign w_sel_src  = w_first ? i_sel   : r_sel_h;
  assign w_decim    = w_first ? i_decim : r_decim_h;
  assign w_win_len  = (w_decim == '0) ? DECIM_WIDTH'(1) : w_decim;
  assign w_win_last = (r_win_cnt == (w_win_len - DECIM_WIDTH'(1)));

  assign o_sel_eff  = (32'(w_sel_src) >= 32'(NUM_CHANNELS)) ? '0 : w_sel_src[CH_W-1:0];

  // PEAK ranks frames by their AVERAGE reduction; a tie keeps the earlier frame.
  assign w_fv       = (w_mode == MODE_SELECT) ? i_sel_val : i_avg;
  assign w_peak_nxt = (w_first || (mag(w_fv) > mag(r_peak))) ? w_fv : r_peak;

  assign o_result   = (w_mode == MODE_PEAK) ? w_peak_nxt : w_fv;
  assign o_load     = i_frame_vld & w_win_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_cnt <= '0;
    end else if (i_frame_vld) begin
      r_win_cnt <= w_win_last ? '0 : r_win_cnt + DECIM_WIDTH'(1);
    end
  end

  // Window state only matters once r_win_cnt is non-zero, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (i_frame_vld) begin
      r_peak <= w_peak_nxt;
      if (w_first) begin
        r_mode_h  <= i_mode;
        r_sel_h   <= i_sel;
        r_decim_h <= i_decim;
      end
    end
  end

endmodule

// File: rtl/axis_multichannel_sample_reducer.sv
// -----------------------------------------------------------------------------
// axis_multichannel_sample_reducer
//   Reduces NUM_CHANNELS-beat interleaved AXI4-Stream frames to one signed mono
//   sample per decimation window (AVERAGE / SELECT / PEAK), with backpressure.
// Ports
//   S_AXIS_ACLK, S_AXIS_ARESET : clock, synchronous active-high reset
//   S_AXIS_T*                  : input channel beats, TLAST on last channel
//   M_AXIS_T*                  : reduced sample stream
//   mode, sel, decim           : reduction controls, sampled per window
//   frame_err                  : 1-cycle pulse per malformed frame
//   frames_dropped             : saturating malformed-frame count
// -----------------------------------------------------------------------------
module axis_multichannel_sample_reducer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int DECIM_WIDTH  = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    S_AXIS_ACLK,
  input  logic                    S_AXIS_ARESET,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  input  logic                    S_AXIS_TLAST,
  output logic                    S_AXIS_TREADY,
  output logic [SAMPLE_WIDTH-1:0] M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  input  logic [1:0]              mode,
  input  logic [2:0]              sel,
  input  logic [DECIM_WIDTH-1:0]  decim,
  output logic                    frame_err,
  output logic [CNT_WIDTH-1:0]    frames_dropped
);

  localparam int LOG2_CH = $clog2(NUM_CHANNELS);
  localparam int CH_W    = (NUM_CHANNELS > 1) ? LOG2_CH : 1;
  localparam int SUM_W   = SAMPLE_WIDTH + LOG2_CH;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);

  state_e                         r_state, w_state_nxt;
  logic [CH_W-1:0]                r_ch_cnt, w_ch_nxt;
  logic signed [SUM_W-1:0]        r_sum;
  logic signed [SAMPLE_WIDTH-1:0] r_chan [NUM_CHANNELS];
  logic                           r_vld_p0;
  logic signed [SAMPLE_WIDTH-1:0] r_out_p0;
  logic                           r_err;
  logic [CNT_WIDTH-1:0]           r_drop;

  logic                           w_acc;
  logic                           w_collect;
  logic                           w_frame_done;
  logic                           w_err;
  logic                           w_clr;
  logic signed [SAMPLE_WIDTH-1:0] w_samp;
  logic signed [SUM_W-1:0]        w_sum_nxt;
  logic signed [SAMPLE_WIDTH-1:0] w_avg;
  logic signed [SAMPLE_WIDTH-1:0] w_sel_val;
  logic [CH_W-1:0]                w_sel_eff;
  logic                           w_load;
  logic signed [SAMPLE_WIDTH-1:0] w_result;

  function automatic logic signed [SAMPLE_WIDTH-1:0] avg_floor(input logic signed [SUM_W-1:0] s);
    return SAMPLE_WIDTH'(s >>> LOG2_CH);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign S_AXIS_TREADY = ~S_AXIS_ARESET & (~r_vld_p0 | M_AXIS_TREADY);
  assign w_acc         = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_collect     = w_acc & (r_state == ST_COLLECT);

  assign w_samp    = SAMPLE_WIDTH'(extract_sample(64'(S_AXIS_TDATA), DATA_WIDTH, SAMPLE_WIDTH));
  assign w_sum_nxt = r_sum + SUM_W'(w_samp);
  assign w_avg     = avg_floor(w_sum_nxt);
  // The completing beat is not yet in r_chan, so take it from the bus.
  assign w_sel_val = (w_sel_eff == r_ch_cnt) ? w_samp : r_chan[w_sel_eff];

  always_comb begin
    w_state_nxt  = r_state;
    w_ch_nxt     = r_ch_cnt;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    w_clr        = 1'b0;
    if (w_acc) begin
      case (r_state)
        ST_COLLECT: begin
          if (r_ch_cnt == CH_LAST) begin
            w_ch_nxt = '0;
            w_clr    = 1'b1;
            if (S_AXIS_TLAST) begin
              w_frame_done = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_RESYNC;
            end
          end else if (S_AXIS_TLAST) begin
            w_err    = 1'b1;
            w_ch_nxt = '0;
            w_clr    = 1'b1;
          end else begin
            w_ch_nxt = r_ch_cnt + CH_W'(1);
          end
        end
        ST_RESYNC: begin
          if (S_AXIS_TLAST) begin
            w_state_nxt = ST_COLLECT;
            w_ch_nxt    = '0;
          end
        end
        default: w_state_nxt = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_state  <= ST_COLLECT;
      r_ch_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch_cnt <= w_ch_nxt;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_sum <= '0;
    end else if (w_clr) begin
      r_sum <= '0;
    end else if (w_collect) begin
      r_sum <= w_sum_nxt;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (w_collect) begin
      r_chan[r_ch_cnt] <= w_samp;
    end
  end

  sample_window_reducer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DECIM_WIDTH  (DECIM_WIDTH),
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_reducer (
    .i_clk       (S_AXIS_ACLK),
    .i_rst       (S_AXIS_ARESET),
    .i_frame_vld (w_frame_done),
    .i_avg       (w_avg),
    .i_sel_val   (w_sel_val),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_decim     (decim),
    .o_sel_eff   (w_sel_eff),
    .o_load      (w_load),
    .o_result    (w_result)
  );

  // ---- stage p0: output holding register ----
  // A load only happens when the previous result is gone or leaving this cycle.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_vld_p0 <= 1'b0;
      r_out_p0 <= '0;
      r_err    <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_load) begin
        r_vld_p0 <= 1'b1;
        r_out_p0 <= w_result;
      end else if (M_AXIS_TREADY) begin
        r_vld_p0 <= 1'b0;
      end
      r_err <= w_err;
      if (w_err) begin
        r_drop <= sat_inc(r_drop);
      end
    end
  end

  assign M_AXIS_TVALID  = r_vld_p0;
  assign M_AXIS_TDATA   = r_out_p0;
  assign frame_err      = r_err;
  assign frames_dropped = r_drop;

endmodule

// File: tb/tb_axis_multichannel_sample_reducer.sv
`timescale 1ns/1ps
module tb_axis_multichannel_sample_reducer;

  localparam int DW  = 32;
  localparam int SW  = 24;
  localparam int NC  = 2;
  localparam int DCW = 8;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_tdata;
  logic           s_tvalid;
  logic           s_tlast;
  logic           s_tready;
  logic [SW-1:0]  m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic [1:0]     mode;
  logic [2:0]     sel;
  logic [DCW-1:0] decim;
  logic           frame_err;
  logic [CW-1:0]  frames_dropped;

  always #5 clk = ~clk;

  axis_multichannel_sample_reducer #(
    .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC), .DECIM_WIDTH(DCW), .CNT_WIDTH(CW)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESET  (rst),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TREADY  (m_tready),
    .mode           (mode),
    .sel            (sel),
    .decim          (decim),
    .frame_err      (frame_err),
    .frames_dropped (frames_dropped)
  );

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;
  logic [SW-1:0] got_q[$];

  // Transfers and error pulses are observed on the falling edge.
  always @(negedge clk) begin
    if (rst !== 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) got_q.push_back(m_tdata);
    if (frame_err === 1'b1) err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got 0 required 1");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int s);
    logic [7:0] lo;
    lo = 8'($urandom);
    return {s[SW-1:0], lo};
  endfunction

  task automatic send_beat(input int s, input bit last);
    bit rdy;
    bit ok;
    ok = 1'b0;
    s_tdata  = mk(s);
    s_tvalid = 1'b1;
    s_tlast  = last;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input int l, input int r);
    send_beat(l, 1'b0);
    send_beat(r, 1'b1);
  endtask

  task automatic expect_out(input string name, input int exp);
    logic [SW-1:0] e;
    logic [SW-1:0] g;
    e = exp[SW-1:0];
    for (int k = 0; k < 300 && got_q.size() == 0; k++) tick(1);
    if (got_q.size() == 0) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      g = got_q.pop_front();
      check(name, longint'(g), longint'(e));
    end
  endtask

  // Reference model helpers, written from the arithmetic definitions.
  function automatic int ref_avg(input int a, input int b);
    int s;
    s = a + b;
    if (s >= 0) return s / 2;
    return -((-s + 1) / 2);
  endfunction

  function automatic longint iabs(input int x);
    return (x < 0) ? -longint'(x) : longint'(x);
  endfunction

  function automatic int rsamp();
    case ($urandom % 8)
      0: return 8388607;
      1: return -8388608;
      2: return int'($urandom % 21) - 10;
      default: return int'($urandom % 16777216) - 8388608;
    endcase
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [2:0] sel;
    int         l;
    int         r;
    int         exp;
  } vec_t;

  vec_t vecs[12];

  bit            stall_ok;
  bit            hold_ok;
  bit            bp_done;
  logic [SW-1:0] held;
  int            k_wait;
  int            e0;
  int            exp_q[$];
  int            exp_err;
  int            wpos, cm, cs, clen, pk, fv, a, b, kind, nj;
  logic [SW-1:0] g24, e24;
  int            ev;

  initial begin
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    mode = 2'b00; sel = 3'd0; decim = 8'd1;

    vecs[0]  = '{2'b00, 3'd0, 32'h100, 32'h300, 32'h200};
    vecs[1]  = '{2'b00, 3'd0, -3, 0, -2};
    vecs[2]  = '{2'b01, 3'd1, 5, -7, -7};
    vecs[3]  = '{2'b01, 3'd5, 5, -7, 5};
    vecs[4]  = '{2'b01, 3'd0, -100, 200, -100};
    vecs[5]  = '{2'b11, 3'd1, 7, 8, 7};
    vecs[6]  = '{2'b00, 3'd0, -1, 0, -1};
    vecs[7]  = '{2'b00, 3'd0, 8388607, 8388607, 8388607};
    vecs[8]  = '{2'b00, 3'd0, -8388608, -8388608, -8388608};
    vecs[9]  = '{2'b00, 3'd0, 8388607, -8388608, -1};
    vecs[10] = '{2'b10, 3'd0, -5, -6, -6};
    vecs[11] = '{2'b01, 3'd3, 9, 4, 9};

    // Reset state
    tick(3);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_frames_dropped", frames_dropped, 0);
    rst = 1'b0;
    tick(1);
    check("post_rst_s_tready", s_tready, 1);

    // Single-frame vectors, one output per frame
    for (int i = 0; i < 12; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; decim = 8'd1;
      send_frame(vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d_latency", i), m_tvalid, 1);
      expect_out($sformatf("vec%0d_value", i), vecs[i].exp);
    end
    tick(2);

    // PEAK over a 4-frame window
    mode = 2'b10; decim = 8'd4;
    send_frame(10, 10);   tick(3); check("peak_none_1", got_q.size(), 0);
    send_frame(-40, -40); tick(3); check("peak_none_2", got_q.size(), 0);
    send_frame(40, 40);   tick(3); check("peak_none_3", got_q.size(), 0);
    send_frame(-3, -3);
    expect_out("peak_value", -40);
    tick(3);
    check("peak_single", got_q.size(), 0);
    mode = 2'b00; decim = 8'd1;

    // TLAST on beat 0
    e0 = err_pulses;
    send_beat(11, 1'b1);
    tick(3);
    check("short_err_pulse", err_pulses - e0, 1);
    check("short_dropped", frames_dropped, 1);
    check("short_no_out", got_q.size(), 0);
    send_frame(4, 6);
    expect_out("short_recover", 5);

    // Missing TLAST on the last channel -> resync until TLAST
    e0 = err_pulses;
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    send_beat(3, 1'b0);
    send_beat(4, 1'b0);
    tick(3);
    check("resync_err_pulse", err_pulses - e0, 1);
    check("resync_dropped", frames_dropped, 2);
    send_beat(5, 1'b1);
    tick(3);
    check("resync_no_out", got_q.size(), 0);
    check("resync_err_once", err_pulses - e0, 1);
    send_frame(20, 30);
    expect_out("resync_recover", 25);

    // Backpressure: sink stalls 50 cycles while three frames are offered
    m_tready = 1'b0;
    stall_ok = 1'b1; hold_ok = 1'b1; k_wait = 0;
    fork
      begin
        send_frame(100, 102);
        send_frame(-50, -52);
        send_frame(7, 9);
      end
      begin
        while (m_tvalid !== 1'b1 && k_wait < 200) begin tick(1); k_wait++; end
        check("bp_first_valid", m_tvalid, 1);
        held = m_tdata;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (s_tready !== 1'b0) stall_ok = 1'b0;
          if (m_tvalid !== 1'b1 || m_tdata !== held) hold_ok = 1'b0;
          @(posedge clk);
          #1;
        end
        check("bp_stall", stall_ok, 1);
        check("bp_hold", hold_ok, 1);
        check("bp_held_val", held, 101);
        m_tready = 1'b1;
      end
    join
    expect_out("bp_out0", 101);
    expect_out("bp_out1", -51);
    expect_out("bp_out2", 8);
    tick(3);
    check("bp_no_dup", got_q.size(), 0);

    // Reset mid-frame
    send_beat(1000, 1'b0);
    rst = 1'b1;
    tick(1);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_m_tdata", m_tdata, 0);
    check("midrst_dropped", frames_dropped, 0);
    check("midrst_frame_err", frame_err, 0);
    rst = 1'b0;
    tick(1);
    check("midrst_ready_after", s_tready, 1);
    send_frame(300, 500);
    expect_out("midrst_recover", 400);
    tick(3);
    check("midrst_no_partial", got_q.size(), 0);

    // Randomized traffic against the reference model
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    exp_err = 0; wpos = 0; cm = 0; cs = 0; clen = 1; pk = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 300; f++) begin
          if (($urandom % 3) == 0) begin
            mode = 2'($urandom); sel = 3'($urandom); decim = 8'($urandom % 4);
          end
          kind = int'($urandom % 10);
          if (kind == 0) begin
            send_beat(rsamp(), 1'b1);
            exp_err++;
          end else if (kind == 1) begin
            send_beat(rsamp(), 1'b0);
            send_beat(rsamp(), 1'b0);
            exp_err++;
            nj = int'($urandom % 3);
            for (int j = 0; j < nj; j++) send_beat(rsamp(), 1'b0);
            send_beat(rsamp(), 1'b1);
          end else begin
            a = rsamp(); b = rsamp();
            send_frame(a, b);
            if (wpos == 0) begin
              cm = int'(mode); cs = int'(sel); clen = (decim == 0) ? 1 : int'(decim);
            end
            if (cm == 1) fv = (cs == 1) ? b : a;
            else         fv = ref_avg(a, b);
            if (cm == 2 && (wpos == 0 || iabs(fv) > iabs(pk))) pk = fv;
            wpos++;
            if (wpos == clen) begin
              exp_q.push_back((cm == 2) ? pk : fv);
              wpos = 0;
            end
          end
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          m_tready = (($urandom % 4) != 0);
          tick(1);
        end
        m_tready = 1'b1;
      end
    join
    for (int k = 0; k < 300 && got_q.size() < exp_q.size(); k++) tick(1);
    tick(5);
    check("rand_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev  = exp_q.pop_front();
      e24 = ev[SW-1:0];
      g24 = got_q.pop_front();
      check("rand_value", longint'(g24), longint'(e24));
    end
    check("rand_dropped", frames_dropped, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
